address_sequencer: RTL and testbench

Parametrised successor to the core's address register: holds the memory address, loads it from the ALU or PC bus, and steps it by a fixed stride through multi-beat block transfers (LDM/STM-style) with a request/ready handshake to memory. It sits between the datapath buses and the memory port. It also exports the incremented address to the datapath, replacing the separate incrementer bus.

---
 rtl/addr_pkg.sv | 7 +
 rtl/address_incrementer.sv | 11 +
 rtl/address_sequencer.sv | 69 ++++++
 tb/tb_address_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/addr_pkg.sv
// addr_pkg: shared state encoding, load-source selects and default stride for the address sequencer
package addr_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_PC = 1'b1;
  localparam int DEFAULT_STEP = 4;
endpackage

// File: rtl/address_incrementer.sv
// address_incrementer: addr +/- STEP modulo 2^AW (ports: addr, dir 0=inc 1=dec, addr_next)
module address_incrementer #(
  parameter int AW = 32,
  parameter int STEP = 4
) (
  input  logic [AW-1:0] addr,
  input  logic          dir,
  output logic [AW-1:0] addr_next
);
  assign addr_next = dir ? addr - AW'(STEP) : addr + AW'(STEP);
endmodule

// File: rtl/address_sequencer.sv
// address_sequencer: address register with load, strided bursts, memory handshake; ports clk, reset, src_sel, alu_bus, pc_bus, load, burst_start, burst_len, dir, pre, mem_ready, addr, addr_next, mem_req, busy, done, misalign (built only with ADDR_ALIGN_CHECK_EN)
module address_sequencer
  import addr_pkg::*;
#(
  parameter int AW = 32,
  parameter int CNT_W = 5,
  parameter int STEP = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_sel,
  input  logic [AW-1:0]    alu_bus,
  input  logic [AW-1:0]    pc_bus,
  input  logic             load,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             dir,
  input  logic             pre,
  input  logic             mem_ready,
  output logic [AW-1:0]    addr,
  output logic [AW-1:0]    addr_next,
  output logic             mem_req,
  output logic             busy,
  output logic             done,
  output logic             misalign
);
  state_t state;
  logic [CNT_W-1:0] count;
  logic [AW-1:0] base, base_step, addr_d;
  logic start, ld, beat, last, upd;
  assign base = (src_sel == SRC_PC) ? pc_bus : alu_bus;
  address_incrementer #(.AW(AW), .STEP(STEP)) u_inc (.addr(addr), .dir(dir), .addr_next(addr_next));
  // pre-index steps the base before the first beat, so it needs its own adder
  address_incrementer #(.AW(AW), .STEP(STEP)) u_pre (.addr(base), .dir(dir), .addr_next(base_step));
  always_comb begin
    start = state == IDLE && burst_start && burst_len != '0;
    ld = state == IDLE && load && !burst_start;
    beat = state == BURST && mem_ready;
    last = beat && count == CNT_W'(1);
    upd = start || ld || beat;
    addr_d = start ? (pre ? base_step : base) : ld ? base : addr_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      count <= '0;
      done <= 1'b0;
    end else begin
      if (upd) addr <= addr_d;
      if (start) count <= burst_len;
      else if (beat) count <= count - 1'b1;
      state <= start ? BURST : last ? IDLE : state;
      done <= last || (state == IDLE && burst_start && burst_len == '0);
    end
  end
  assign mem_req = state == BURST;
  assign busy = state == BURST;
`ifdef ADDR_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else if (upd) mis_q <= |addr_d[1:0];
  end
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif
endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer: directed self-checking bench for address_sequencer
module tb_address_sequencer;
  logic clk = 0, reset = 1, src_sel = 0, load = 0, burst_start = 0, dir = 0, pre = 0, mem_ready = 0;
  logic [31:0] alu_bus = 0, pc_bus = 0;
  logic [4:0] burst_len = 0;
  logic [31:0] addr, addr_next;
  logic mem_req, busy, done, misalign;
  int n_cmp = 0, n_bad = 0;
  address_sequencer dut (
    .clk(clk), .reset(reset), .src_sel(src_sel), .alu_bus(alu_bus), .pc_bus(pc_bus),
    .load(load), .burst_start(burst_start), .burst_len(burst_len), .dir(dir), .pre(pre),
    .mem_ready(mem_ready), .addr(addr), .addr_next(addr_next), .mem_req(mem_req),
    .busy(busy), .done(done), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic burst3(input logic [31:0] base, input logic d, input logic p,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] efin);
    logic [31:0] e[3];
    e = '{e0, e1, e2};
    src_sel = 0; alu_bus = base; burst_len = 3; dir = d; pre = p; mem_ready = 1; burst_start = 1;
    tick();
    burst_start = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("beat%0d_addr", i), addr, e[i]);
      chk($sformatf("beat%0d_req", i), {31'b0, mem_req}, 1);
      chk($sformatf("beat%0d_done", i), {31'b0, done}, 0);
      tick();
    end
    chk("burst_done", {31'b0, done}, 1);
    chk("burst_busy_end", {31'b0, busy}, 0);
    chk("burst_final", addr, efin);
    tick();
    chk("done_one_cycle", {31'b0, done}, 0);
  endtask
  initial begin
    logic rdy[5];
    logic [31:0] ra[5];
    logic dn[5];
    rdy = '{1, 0, 0, 1, 1};
    ra = '{32'h304, 32'h304, 32'h304, 32'h308, 32'h30C};
    dn = '{0, 0, 0, 0, 1};
    tick(); tick();
    reset = 0;
    chk("rst_addr", addr, 0);
    chk("rst_next", addr_next, 4);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_mis", {31'b0, misalign}, 0);
    src_sel = 1; pc_bus = 32'h100; load = 1;
    tick();
    load = 0;
    chk("load_addr", addr, 32'h100);
    chk("load_next", addr_next, 32'h104);
    chk("load_busy", {31'b0, busy}, 0);
    burst3(32'h200, 0, 0, 32'h200, 32'h204, 32'h208, 32'h20C);
    burst3(32'h200, 1, 1, 32'h1FC, 32'h1F8, 32'h1F4, 32'h1F0);
    burst3(32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4);
    src_sel = 0; alu_bus = 32'h300; burst_len = 3; dir = 0; pre = 0; burst_start = 1;
    tick();
    burst_start = 0;
    chk("stall_start", addr, 32'h300);
    chk("stall_next_inc", addr_next, 32'h304);
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      tick();
      chk($sformatf("stall%0d_addr", i), addr, ra[i]);
      chk($sformatf("stall%0d_done", i), {31'b0, done}, {31'b0, dn[i]});
    end
    chk("stall_busy_end", {31'b0, busy}, 0);
    burst_len = 0; burst_start = 1;
    tick();
    burst_start = 0;
    chk("zero_req", {31'b0, mem_req}, 0);
    chk("zero_busy", {31'b0, busy}, 0);
    chk("zero_done", {31'b0, done}, 1);
    chk("zero_addr", addr, 32'h30C);
    tick();
    chk("zero_done_clr", {31'b0, done}, 0);
    alu_bus = 32'h400; burst_len = 5; mem_ready = 1; burst_start = 1;
    tick();
    burst_start = 0;
    load = 1; alu_bus = 32'h900;
    tick();
    load = 0;
    chk("burst_ignores_load", addr, 32'h404);
    chk("burst_next_dec_off", addr_next, 32'h408);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_addr", addr, 0);
    chk("abort_req", {31'b0, mem_req}, 0);
    chk("abort_done", {31'b0, done}, 0);
    tick();
    chk("abort_done2", {31'b0, done}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    alu_bus = 32'h102; load = 1;
    tick();
    load = 0;
    chk("mis_addr", addr, 32'h102);
    chk("mis_next", addr_next, 32'h106);
`ifdef ADDR_ALIGN_CHECK_EN
    chk("mis_set", {31'b0, misalign}, 1);
`else
    chk("mis_tied", {31'b0, misalign}, 0);
`endif
    alu_bus = 32'h104; load = 1;
    tick();
    load = 0;
    chk("mis_clear", {31'b0, misalign}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
